// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: write-back source select codes,
// load-type codes and the widths of those two fields.
package wb_pkg;

   localparam int WBSEL_W  = 2;
   localparam int LDTYPE_W = 3;

   // Write-back source select; code 2'b11 is reserved and writes zero.
   localparam logic [WBSEL_W-1:0] WBSEL_ALU  = 2'b00;
   localparam logic [WBSEL_W-1:0] WBSEL_LOAD = 2'b01;
   localparam logic [WBSEL_W-1:0] WBSEL_LINK = 2'b10;

   // Load kinds; unlisted codes behave like LW.
   localparam logic [LDTYPE_W-1:0] LD_LW  = 3'b000;
   localparam logic [LDTYPE_W-1:0] LD_LH  = 3'b001;
   localparam logic [LDTYPE_W-1:0] LD_LHU = 3'b010;
   localparam logic [LDTYPE_W-1:0] LD_LB  = 3'b011;
   localparam logic [LDTYPE_W-1:0] LD_LBU = 3'b100;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle plus the register-file write port and WB status outputs.
// slave = the write-back stage, master = its environment (MEM stage / regfile).
interface wb_stage_if;
   import wb_pkg::*;

   logic                stall;
   logic                flush;
   logic                mem_valid;
   logic                mem_regwrite;
   logic [4:0]          mem_rd;
   logic [WBSEL_W-1:0]  mem_wbsel;
   logic [LDTYPE_W-1:0] mem_ldtype;
   logic [31:0]         mem_alu_res;
   logic [31:0]         mem_rdata;
   logic [31:0]         mem_pc;

   logic                gpr_we;
   logic [4:0]          gpr_a3;
   logic [31:0]         gpr_wd;
   logic                wb_valid;
   logic [31:0]         wb_pc;
   logic [31:0]         instret;

   modport master (
      output stall, flush, mem_valid, mem_regwrite, mem_rd, mem_wbsel,
             mem_ldtype, mem_alu_res, mem_rdata, mem_pc,
      input  gpr_we, gpr_a3, gpr_wd, wb_valid, wb_pc, instret
   );

   modport slave (
      input  stall, flush, mem_valid, mem_regwrite, mem_rd, mem_wbsel,
             mem_ldtype, mem_alu_res, mem_rdata, mem_pc,
      output gpr_we, gpr_a3, gpr_wd, wb_valid, wb_pc, instret
   );

endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed byte/half out of a little-endian read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
   import wb_pkg::*;
(
   input  logic [LDTYPE_W-1:0] ldtype,
   input  logic [1:0]          addr,
   input  logic [31:0]         rdata,
   output logic [31:0]         data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then extension; unknown load kinds pass the whole word.
   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
      case (ldtype)
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'h0000, half_sel};
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'h000000, byte_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage. Holds the MEM/WB pipeline register, drives
// the register-file write port and counts retired instructions.
// Optional macro WB_TRACE_EN: prints "<pc>: <rd> <data>" for every committed
// register write (simulation only; no hardware change).
module wb_stage
   import wb_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [31:0] LINK_OFFSET = 32'd8
) (
   input  logic       clk,
   input  logic       reset,
   wb_stage_if.slave  wb
);

   logic                valid_reg;
   logic                regwrite_reg;
   logic [4:0]          rd_reg;
   logic [WBSEL_W-1:0]  wbsel_reg;
   logic [LDTYPE_W-1:0] ldtype_reg;
   logic [31:0]         alu_res_reg;
   logic [31:0]         rdata_reg;
   logic [31:0]         pc_reg;
   logic [31:0]         instret_reg;
   logic [31:0]         load_data;
   logic [31:0]         wd_next;

   // MEM/WB register: flush beats stall beats load; flush only kills the
   // valid/regwrite bits and leaves the payload in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg    <= 1'b0;
         regwrite_reg <= 1'b0;
         rd_reg       <= 5'd0;
         wbsel_reg    <= WBSEL_ALU;
         ldtype_reg   <= LD_LW;
         alu_res_reg  <= 32'h0;
         rdata_reg    <= 32'h0;
         pc_reg       <= RESET_PC;
      end else if (wb.flush) begin
         valid_reg    <= 1'b0;
         regwrite_reg <= 1'b0;
      end else if (!wb.stall) begin
         valid_reg    <= wb.mem_valid;
         regwrite_reg <= wb.mem_regwrite;
         rd_reg       <= wb.mem_rd;
         wbsel_reg    <= wb.mem_wbsel;
         ldtype_reg   <= wb.mem_ldtype;
         alu_res_reg  <= wb.mem_alu_res;
         rdata_reg    <= wb.mem_rdata;
         pc_reg       <= wb.mem_pc;
      end
   end

   // Retire counter: an instruction is counted on the edge it leaves WB,
   // so a stalled instruction is counted exactly once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_reg <= 32'h0;
      end else if (valid_reg && !wb.stall) begin
         instret_reg <= instret_reg + 32'd1;
      end
   end

   load_align u_load_align (
      .ldtype (ldtype_reg),
      .addr   (alu_res_reg[1:0]),
      .rdata  (rdata_reg),
      .data   (load_data)
   );

   // Write-back source mux, fed only from registered state so gpr_wd is
   // stable for the whole cycle.
   always_comb begin
      case (wbsel_reg)
         WBSEL_ALU:  wd_next = alu_res_reg;
         WBSEL_LOAD: wd_next = load_data;
         WBSEL_LINK: wd_next = pc_reg + LINK_OFFSET;
         default:    wd_next = 32'h0;
      endcase
   end

   assign wb.gpr_we   = valid_reg & regwrite_reg & (rd_reg != 5'd0);
   assign wb.gpr_a3   = rd_reg;
   assign wb.gpr_wd   = wd_next;
   assign wb.wb_valid = valid_reg;
   assign wb.wb_pc    = pc_reg;
   assign wb.instret  = instret_reg;

`ifdef WB_TRACE_EN
   // One trace line per committed write (the edge on which it is not stalled).
   always @(posedge clk) begin
      if (!reset && wb.gpr_we && !wb.stall)
         $display("%h: %d %x", pc_reg, rd_reg, wd_next);
   end
`endif

endmodule
